rx_sequencer: RTL and testbench
===============================

# rx_sequencer

Bit-level timing and control sequencer for the serial receive path. It starts on a one-cycle start-bit pulse from the edge detector, re-checks the start bit at mid-bit, and emits one mid-bit shift strobe per data bit plus the stop bit. It then checks the stop bit and either loads the receive buffer or flags a framing error. It drives the shift register, the stop-bit logic and the receive data buffer.

## Interface
- CLKS_PER_BIT, 10, clock cycles per serial bit; legal range 4..255.
- DATA_BITS, 8, data bits per frame; legal range 5..9.

- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous reset, active low.
- serial_in  input  1  synchronized serial line, idle high.
- start_bit_detected  input  1  one-cycle pulse on a line falling edge.
- shift_strobe  output  1  one-cycle pulse at each mid-bit sample point.
- sbc_clear  output  1  clears the stop-bit/error logic at frame start.
- sbc_enable  output  1  stop-bit check enable, one cycle.
- load_buffer  output  1  one-cycle pulse that loads the received byte.
- framing_error  output  1  registered; set when the stop bit is 0.
- parity_error  output  1  registered; tied 0 unless parity is compiled in.
- busy  output  1  high in every state except IDLE.

Clock is `clk`. Reset is `n_rst`, asynchronous and active-low.

## Operation
- The state machine has five states: IDLE, START_WAIT, RECEIVE, STOP_CHK and LOAD.
- HALF = CLKS_PER_BIT/2, using integer division.
- NBITS = DATA_BITS+1, which counts the data bits plus the stop bit.
- **IDLE**
  - start_bit_detected=1 moves to START_WAIT and clears the cycle counter.
  - All other inputs are ignored.
- **START_WAIT**
  - sbc_clear=1 in the first cycle only.
  - framing_error and parity_error clear on that same edge.
  - Lasts exactly HALF cycles.
  - In the last cycle, serial_in=1 is a false start and returns to IDLE with no further outputs.
  - serial_in=0 moves to RECEIVE, with the cycle counter at 0 and the bit counter at 0.
- **RECEIVE**
  - The cycle counter increments every cycle and wraps from CLKS_PER_BIT-1 to 0.
  - shift_strobe = (state==RECEIVE && cyc_cnt==CLKS_PER_BIT-1).
  - The bit counter increments on each strobe.
  - On the last strobe (bit counter = NBITS-1):
    - serial_in is latched as stop_bit;
    - the state moves to STOP_CHK.
- **STOP_CHK**
  - Lasts one cycle, with sbc_enable=1.
  - framing_error <= ~stop_bit.
  - Next state is LOAD if there is no error, otherwise IDLE.
- **LOAD**
  - Lasts one cycle, with load_buffer=1.
  - Next state is IDLE.
- start_bit_detected is ignored in every state other than IDLE.
- Error flags hold until the next accepted START_WAIT entry.
- shift_strobe, sbc_clear, sbc_enable, load_buffer and busy are decoded from the state and counters. They are glitch-free Moore outputs.
- Counter widths:
  - cycle counter: $clog2(CLKS_PER_BIT);
  - bit counter: $clog2(NBITS+2).

## Timing
- Reset value of every output is 0. The state resets to IDLE and the counters reset to 0.
- Reset asserted mid-frame returns to IDLE immediately. No load_buffer pulse is produced.
- Timeline with start_bit_detected high in cycle 0:
  - START_WAIT occupies cycles 1..HALF;
  - strobe k (k=1..NBITS) falls in cycle HALF + k·CLKS_PER_BIT;
  - STOP_CHK is the following cycle;
  - LOAD is the cycle after that.
- With defaults:
  - strobes at cycles 15, 25, …, 95;
  - STOP_CHK at cycle 96;
  - load_buffer at cycle 97;
  - busy high in cycles 1..97 and back to IDLE in cycle 98.
- A new start_bit_detected is accepted from cycle 98 onward.
- A pulse in cycle 97 or earlier is dropped.

## Configuration
- **Without `RX_SEQ_PARITY_EN`**
  - Frames are as described above.
  - parity_error is constant 0.
- **With `RX_SEQ_PARITY_EN`**
  - NBITS = DATA_BITS+2: data bits, then one even-parity bit, then the stop bit.
  - A running XOR is taken of serial_in at the first DATA_BITS+1 strobes.
  - In STOP_CHK, parity_error <= XOR.
  - A parity error or a framing error suppresses LOAD and returns to IDLE.
  - With defaults, STOP_CHK moves to cycle 106.

## Structure
- Package rx_seq_pkg holds:
  - the state enum typedef rx_seq_state_t;
  - default constants RX_DEF_CLKS_PER_BIT=10 and RX_DEF_DATA_BITS=8.
- One sub-module, rx_bit_timer:
  - contains the cycle counter and bit counter;
  - inputs: an enable, a synchronous clear, and NBITS;
  - outputs: shift_strobe and a last_bit flag.
- The FSM, error registers and parity XOR stay in rx_sequencer.

## Test plan
- Reset, then an idle line for 50 cycles -> all outputs 0 and busy=0.
- Default parameters, frame 0xA5 sent LSB first with stop bit 1 -> 9 strobes at cycles 15..95, sbc_enable at 96, load_buffer at 97, framing_error=0.
- Same frame with stop bit 0 -> sbc_enable at 96, no load_buffer, framing_error=1 until the next start.
- start_bit_detected pulse with serial_in back at 1 by cycle 5 -> return to IDLE at cycle 6, zero strobes.
- n_rst asserted at cycle 40 of a frame -> all outputs 0 immediately; the next frame is received normally.
- With RX_SEQ_PARITY_EN and data 0x07 with parity bit 0 -> 10 strobes, parity_error=1 at cycle 107, no load_buffer.

Source files
------------

// File: rtl/rx_seq_pkg.sv
// Shared types and defaults for the serial receive sequencer.
// Optional parity support is selected with RX_SEQ_PARITY_EN.
package rx_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_WAIT,
        RECEIVE,
        STOP_CHK,
        LOAD
    } rx_seq_state_t;

    localparam int RX_DEF_CLKS_PER_BIT = 10;
    localparam int RX_DEF_DATA_BITS    = 8;

endpackage

// File: rtl/rx_bit_timer.sv
// Cycle and bit counters for the receive sequencer.
// Produces the mid-bit strobe tick and the last-bit flag.
module rx_bit_timer
    import rx_seq_pkg::*;
#(
    parameter int CLKS_PER_BIT = RX_DEF_CLKS_PER_BIT,
    parameter int BW           = 4,
    localparam int CW          = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic [BW-1:0] i_nbits,
    output logic [CW-1:0] o_cyc,
    output logic          o_shift_strobe,
    output logic          o_last_bit
);

    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cyc;
    logic [BW-1:0] r_bit;

    // Cycle counter wraps each bit period; bit counter advances on wrap
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cyc <= '0;
            r_bit <= '0;
        end else if (i_clr) begin
            r_cyc <= '0;
            r_bit <= '0;
        end else if (i_en) begin
            if (r_cyc == CYC_LAST) begin
                r_cyc <= '0;
                r_bit <= r_bit + 1'b1;
            end else begin
                r_cyc <= r_cyc + 1'b1;
            end
        end
    end

    assign o_cyc          = r_cyc;
    assign o_shift_strobe = i_en && (r_cyc == CYC_LAST);
    assign o_last_bit     = (r_bit == (i_nbits - BW'(1)));

endmodule

// File: rtl/rx_sequencer.sv
// Bit-level timing/control FSM for the serial receive path.
// Define RX_SEQ_PARITY_EN to add an even-parity bit before the stop bit.
module rx_sequencer
    import rx_seq_pkg::*;
#(
    parameter int CLKS_PER_BIT = RX_DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = RX_DEF_DATA_BITS
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic start_bit_detected,
    output logic shift_strobe,
    output logic sbc_clear,
    output logic sbc_enable,
    output logic load_buffer,
    output logic framing_error,
    output logic parity_error,
    output logic busy
);

`ifdef RX_SEQ_PARITY_EN
    localparam int NBITS = DATA_BITS + 2;
`else
    localparam int NBITS = DATA_BITS + 1;
`endif
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int BW   = $clog2(NBITS + 2);
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [BW-1:0] NB        = BW'(NBITS);

    rx_seq_state_t r_state;
    rx_seq_state_t w_next;

    logic          w_en;
    logic          w_clr;
    logic [CW-1:0] w_cyc;
    logic          w_strobe;
    logic          w_last;
    logic          w_err;
    logic          r_stop_bit;
    logic          r_fe;

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .BW           (BW)
    ) u_timer (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_en           (w_en),
        .i_clr          (w_clr),
        .i_nbits        (NB),
        .o_cyc          (w_cyc),
        .o_shift_strobe (w_strobe),
        .o_last_bit     (w_last)
    );

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and counter control
    always_comb begin
        w_next = r_state;
        w_en   = 1'b0;
        w_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (start_bit_detected) w_next = START_WAIT;
            end
            START_WAIT: begin
                w_en = 1'b1;
                if (w_cyc == HALF_LAST) begin
                    w_clr  = 1'b1;
                    w_next = serial_in ? IDLE : RECEIVE;
                end
            end
            RECEIVE: begin
                w_en = 1'b1;
                if (w_strobe && w_last) w_next = STOP_CHK;
            end
            STOP_CHK: begin
                w_clr  = 1'b1;
                w_next = w_err ? IDLE : LOAD;
            end
            LOAD: begin
                w_clr  = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_clr  = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    // Latch the line at the final strobe as the stop bit
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_stop_bit <= 1'b0;
        else if (shift_strobe && w_last)
            r_stop_bit <= serial_in;
    end

    // Framing flag: cleared at frame start, updated at stop check
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)          r_fe <= 1'b0;
        else if (sbc_clear)  r_fe <= 1'b0;
        else if (sbc_enable) r_fe <= ~r_stop_bit;
    end

`ifdef RX_SEQ_PARITY_EN
    logic r_par;
    logic r_pe;

    // Running XOR over data and parity strobes; parity flag at stop check
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_par <= 1'b0;
            r_pe  <= 1'b0;
        end else if (sbc_clear) begin
            r_par <= 1'b0;
            r_pe  <= 1'b0;
        end else if (shift_strobe && !w_last) begin
            r_par <= r_par ^ serial_in;
        end else if (sbc_enable) begin
            r_pe  <= r_par;
        end
    end

    assign w_err        = ~r_stop_bit | r_par;
    assign parity_error = r_pe;
`else
    assign w_err        = ~r_stop_bit;
    assign parity_error = 1'b0;
`endif

    assign shift_strobe  = (r_state == RECEIVE) && w_strobe;
    assign sbc_clear     = (r_state == START_WAIT) && (w_cyc == '0);
    assign sbc_enable    = (r_state == STOP_CHK);
    assign load_buffer   = (r_state == LOAD);
    assign busy          = (r_state != IDLE);
    assign framing_error = r_fe;

endmodule

// File: tb/tb_rx_sequencer.sv
// Directed bench for rx_sequencer with default parameters.
// Cycle 0 of each frame is the cycle carrying start_bit_detected.
module tb_rx_sequencer;

    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;
`ifdef RX_SEQ_PARITY_EN
    localparam int NB   = 10;
`else
    localparam int NB   = 9;
`endif
    localparam int STOP = HALF + NB * CPB + 1;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic serial_in = 1'b1;
    logic start_bit_detected = 1'b0;
    logic shift_strobe, sbc_clear, sbc_enable, load_buffer;
    logic framing_error, parity_error, busy;

    int n_chk = 0;
    int n_pass = 0;

    int st_cnt, st_bad, clr_cnt, clr_cyc, en_cnt, en_cyc;
    int ld_cnt, ld_cyc, busy_first, busy_last, busy_at0;
    int fe_end, pe_end, rst_bad, idle_bad;

    rx_sequencer u_dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .serial_in          (serial_in),
        .start_bit_detected (start_bit_detected),
        .shift_strobe       (shift_strobe),
        .sbc_clear          (sbc_clear),
        .sbc_enable         (sbc_enable),
        .load_buffer        (load_buffer),
        .framing_error      (framing_error),
        .parity_error       (parity_error),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic s);
`ifdef RX_SEQ_PARITY_EN
        return {1'b0, s, ^d, d};
`else
        return {2'b00, s, d};
`endif
    endfunction

    function automatic int outs();
        return int'({shift_strobe, sbc_clear, sbc_enable, load_buffer,
                     framing_error, parity_error, busy});
    endfunction

    // Entered and left 1 time unit after a rising edge
    task automatic run(input logic [10:0] bits, input int ncyc,
                       input int fs_at, input int rst_at, input int drop_at);
        st_cnt = 0; st_bad = 0; clr_cnt = 0; clr_cyc = -1;
        en_cnt = 0; en_cyc = -1; ld_cnt = 0; ld_cyc = -1;
        busy_first = -1; busy_last = -1; busy_at0 = -1; rst_bad = -1;
        for (int c = 0; c < ncyc; c++) begin
            start_bit_detected = (c == 0) || (c == drop_at);
            if (c < CPB) serial_in = (fs_at >= 0) && (c >= fs_at);
            else if (c / CPB - 1 < NB) serial_in = bits[c / CPB - 1];
            else serial_in = 1'b1;
            if (c == rst_at) n_rst = 1'b0;
            @(negedge clk);
            if (c == rst_at) begin
                rst_bad = outs();
                break;
            end
            if (c == 0) busy_at0 = int'(busy);
            if (shift_strobe) begin
                st_cnt++;
                if (c < HALF + CPB || (c - HALF) % CPB != 0) st_bad++;
            end
            if (sbc_clear)   begin clr_cnt++; clr_cyc = c; end
            if (sbc_enable)  begin en_cnt++;  en_cyc = c;  end
            if (load_buffer) begin ld_cnt++;  ld_cyc = c;  end
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            fe_end = int'(framing_error);
            pe_end = int'(parity_error);
            @(posedge clk);
            #1;
        end
        start_bit_detected = 1'b0;
        serial_in = 1'b1;
    endtask

    task automatic idle(input int n);
        idle_bad = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (busy || shift_strobe || sbc_clear || sbc_enable || load_buffer)
                idle_bad++;
            fe_end = int'(framing_error);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        @(negedge clk);
        check("reset_outs", outs(), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        idle(50);
        check("idle_quiet", idle_bad, 0);
        check("idle_fe", fe_end, 0);

        // Good frame; a start pulse during LOAD must be dropped
        run(frame(8'hA5, 1'b1), STOP + 2, -1, -1, STOP + 1);
        check("a_idle0", busy_at0, 0);
        check("a_strobes", st_cnt, NB);
        check("a_strobe_pos", st_bad, 0);
        check("a_clr_cyc", clr_cyc, 1);
        check("a_clr_cnt", clr_cnt, 1);
        check("a_en_cyc", en_cyc, STOP);
        check("a_en_cnt", en_cnt, 1);
        check("a_ld_cyc", ld_cyc, STOP + 1);
        check("a_ld_cnt", ld_cnt, 1);
        check("a_busy_first", busy_first, 1);
        check("a_busy_last", busy_last, STOP + 1);
        check("a_fe", fe_end, 0);
        check("a_pe", pe_end, 0);

        // Starts at cycle STOP+2 of the previous frame: must be accepted
        run(frame(8'hA5, 1'b0), STOP + 2, -1, -1, -1);
        check("b_idle0", busy_at0, 0);
        check("b_clr_cyc", clr_cyc, 1);
        check("b_strobes", st_cnt, NB);
        check("b_en_cyc", en_cyc, STOP);
        check("b_ld_cnt", ld_cnt, 0);
        check("b_busy_last", busy_last, STOP);
        check("b_fe", fe_end, 1);
        idle(20);
        check("b_fe_hold", fe_end, 1);
        check("b_idle_quiet", idle_bad, 0);

        // False start: line back high by cycle 5
        run(11'h000, 12, 5, -1, -1);
        check("c_clr_cyc", clr_cyc, 1);
        check("c_strobes", st_cnt, 0);
        check("c_busy_last", busy_last, HALF);
        check("c_en_cnt", en_cnt, 0);
        check("c_fe_cleared", fe_end, 0);

        // Reset asserted at cycle 40 of a frame
        run(frame(8'hA5, 1'b1), 60, -1, 40, -1);
        check("d_rst_outs", rst_bad, 0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        idle(3);
        check("d_idle_quiet", idle_bad, 0);
        run(frame(8'h3C, 1'b1), STOP + 2, -1, -1, -1);
        check("e_strobes", st_cnt, NB);
        check("e_strobe_pos", st_bad, 0);
        check("e_ld_cyc", ld_cyc, STOP + 1);
        check("e_fe", fe_end, 0);

`ifdef RX_SEQ_PARITY_EN
        // Data 0x07 with parity bit 0: odd ones count
        run({1'b0, 1'b1, 1'b0, 8'h07}, STOP + 2, -1, -1, -1);
        check("p_strobes", st_cnt, NB);
        check("p_en_cyc", en_cyc, STOP);
        check("p_ld_cnt", ld_cnt, 0);
        check("p_pe", pe_end, 1);
        check("p_fe", fe_end, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
